lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receiving end of the 11-bit LFSR pseudo-random stream. The generator shifts 2 bits per step and emits lfsr[1:0] each step.
- The checker captures the incoming 2-bit samples, reconstructs the generator state and locks to it. It then predicts every following sample and counts mismatches.
- It is used as a self-check monitor on random-replacement and stimulus paths in the core and in simulation.

Parameters:
- LFSR_BITS, 11, generator state width. Only 11 is legal; any other value is an elaboration error.
- RAND_BITS, 2, bits per sample. Only 2 is legal.
- LOCK_COUNT, 8, consecutive matching samples required in CONFIRM before lock.
- LOSS_COUNT, 4, consecutive mismatches in LOCKED that drop lock.
- CNT_W, 16, width of the saturating statistic counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bits carries a sample this cycle.
- in_bits  in  RAND_BITS  received sample, equal to generator lfsr[1:0].
- clear_stats  in  1  synchronous clear of err_count and sample_count.
- locked  out  1  checker is locked to the stream.
- err_pulse  out  1  one-cycle pulse per mismatching sample while LOCKED.
- err_count  out  CNT_W  saturating mismatch count.
- sample_count  out  CNT_W  saturating count of valid samples.
- state_out  out  2  current FSM state encoding.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - FSM = HUNT, locked = 0, err_pulse = 0.
  - err_count = 0, sample_count = 0.
  - capture register = 0, fill counter = 0, match/miss counters = 0.
- Step function N(s):
  - n[8:0] = s[10:2]
  - n[9] = s[0]^s[2]
  - n[10] = s[1]^s[3]
- Only cycles with in_valid=1 advance any state. in_valid=0 holds everything, and err_pulse=0.
- State encoding: HUNT=0, CONFIRM=1, LOCKED=2.
- HUNT:
  - Each sample updates cap[11:0] <= {in_bits, cap[11:2]} and increments the fill counter.
  - On the 6th sample, the candidate s = next_cap[10:0] is the generator state at the first sample.
  - If s == 0: restart the fill counter and remain in HUNT.
  - Otherwise: exp <= N^6(s) (unrolled combinational), match counter = 0, go to CONFIRM.
- CONFIRM:
  - Each sample compares in_bits with exp[1:0], then exp <= N(exp).
  - Match: increment the match counter. On the LOCK_COUNT-th match go to LOCKED; locked=1 from the next cycle.
  - Mismatch: go to HUNT with the fill counter cleared. No error is counted.
- LOCKED:
  - Same compare and advance as CONFIRM.
  - Mismatch: err_pulse=1 on the next cycle, err_count++ (saturates at all-ones), miss counter++.
  - Match: miss counter = 0.
  - On the LOSS_COUNT-th consecutive mismatch: go to HUNT and locked=0 on the next cycle. This last mismatch is still counted.
- Counters:
  - sample_count increments on every valid sample in any state and saturates.
  - clear_stats zeroes both counters. If a sample arrives in the same cycle, clear wins, so the result is 0, not 1.
  - clear_stats does not affect the FSM.
- All outputs are registered. Errors are only counted in LOCKED.
- An asynchronous reset mid-stream returns to HUNT immediately. No sample is lost from the checker's point of view; it simply relocks.

Optional Feature:
- Macro: LFSR_CHECK_HIST_EN.
- Defined:
  - Adds output hist_count, 4*CNT_W wide: four saturating counters, one per in_bits value, slice i = value i.
  - Each valid sample increments its counter in any state.
  - The counters are cleared by reset and by clear_stats.
- Undefined: the port and the counters are absent.

Test Plan:
- Clean lock: reset, then feed the generator stream from seed 11'd101 with in_valid=1 every cycle.
  - locked=1 the cycle after the 14th sample (6 fill + 8 confirm).
  - err_count=0 after 2047 samples; sample_count=2047.
- Single error: after lock, flip in_bits[0] of one sample.
  - err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
- Loss and relock: after lock, corrupt 4 consecutive samples.
  - err_count=4, locked=0.
  - Resume the clean stream: locked=1 again 14 samples later.
- All-zero input: 100 valid samples of 2'b00.
  - Stays in HUNT, locked=0, err_count=0, sample_count=100.
- Gaps and clear: the clean stream with in_valid toggling 1/0.
  - Locks after 14 valid samples.
  - Pulse clear_stats together with a valid sample: both counters read 0 the next cycle.
- Histogram (LFSR_CHECK_HIST_EN): 2047 clean samples from seed 101.
  - hist 00=511, 01=512, 10=512, 11=512.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks to a 2-bit-per-step 11-bit LFSR stream, predicts it and counts mismatches
// Ports: clock/reset (async, active-high); in_valid/in_bits: received sample;
// clear_stats: sync clear of counters; locked, err_pulse, err_count, sample_count,
// state_out (HUNT=0, CONFIRM=1, LOCKED=2). Define LFSR_CHECK_HIST_EN to add
// hist_count: four per-value saturating sample counters, slice i = value i.
module lfsr_checker #(
  parameter int LFSR_BITS  = 11,
  parameter int RAND_BITS  = 2,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [RAND_BITS-1:0] in_bits,
  input  logic                 clear_stats,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     sample_count,
`ifdef LFSR_CHECK_HIST_EN
  output logic [4*CNT_W-1:0]   hist_count,
`endif
  output logic [1:0]           state_out
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  if (LFSR_BITS != 11 || RAND_BITS != 2) begin : g_bad_params
    $error("lfsr_checker supports only LFSR_BITS=11 and RAND_BITS=2");
  end
  typedef enum logic [1:0] {HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2} state_t;
  function automatic logic [10:0] step(input logic [10:0] s);
    return {s[1] ^ s[3], s[0] ^ s[2], s[10:2]};
  endfunction
  function automatic logic [10:0] step6(input logic [10:0] s);
    for (int i = 0; i < 6; i++) s = step(s);
    return s;
  endfunction
  state_t state, state_n;
  logic [9:0] cap, cap_n;
  logic [2:0] fill, fill_n;
  logic [10:0] exp_q, exp_n, cand;
  logic [MW-1:0] match, match_n;
  logic [LW-1:0] miss, miss_n;
  logic hit, err;
  // Only the five previous samples are kept; the sixth arrives on in_bits and
  // its upper bit falls outside the 11-bit state.
  assign cand = {in_bits[0], cap};
  assign hit = in_bits == exp_q[1:0];
  assign err = in_valid && state == LOCKED && !hit;
  assign state_out = state;
  always_comb begin
    state_n = state;
    cap_n = cap;
    fill_n = fill;
    exp_n = exp_q;
    match_n = match;
    miss_n = miss;
    if (in_valid)
      case (state)
        HUNT: begin
          cap_n = {in_bits, cap[9:2]};
          fill_n = fill + 3'd1;
          if (fill == 3'd5) begin
            fill_n = '0;
            if (cand != '0) begin
              exp_n = step6(cand);
              match_n = '0;
              state_n = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          exp_n = step(exp_q);
          match_n = match + 1'b1;
          if (!hit) begin
            state_n = HUNT;
            fill_n = '0;
          end else if (match == MW'(LOCK_COUNT - 1)) begin
            state_n = LOCKED;
            miss_n = '0;
          end
        end
        LOCKED: begin
          exp_n = step(exp_q);
          miss_n = hit ? '0 : miss + 1'b1;
          if (!hit && miss == LW'(LOSS_COUNT - 1)) begin
            state_n = HUNT;
            fill_n = '0;
          end
        end
        default: state_n = HUNT;
      endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= HUNT;
      cap <= '0;
      fill <= '0;
      exp_q <= '0;
      match <= '0;
      miss <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      sample_count <= '0;
    end else begin
      state <= state_n;
      cap <= cap_n;
      fill <= fill_n;
      exp_q <= exp_n;
      match <= match_n;
      miss <= miss_n;
      locked <= state_n == LOCKED;
      err_pulse <= err;
      if (clear_stats) begin
        err_count <= '0;
        sample_count <= '0;
      end else begin
        if (in_valid && sample_count != '1) sample_count <= sample_count + 1'b1;
        if (err && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
`ifdef LFSR_CHECK_HIST_EN
  logic [CNT_W-1:0] hist [4];
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < 4; i++) hist[i] <= '0;
    else
      for (int i = 0; i < 4; i++)
        if (clear_stats) hist[i] <= '0;
        else if (in_valid && in_bits == 2'(i) && hist[i] != '1) hist[i] <= hist[i] + 1'b1;
  for (genvar g = 0; g < 4; g++) begin : g_hist
    assign hist_count[g*CNT_W +: CNT_W] = hist[g];
  end
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table, directed and random checks of lfsr_checker against a sample-level model
module tb_lfsr_checker;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, clear_stats = 1'b0;
  logic [1:0] in_bits = 2'd0;
  logic locked, err_pulse;
  logic [15:0] err_count, sample_count;
  logic [1:0] state_out;
`ifdef LFSR_CHECK_HIST_EN
  logic [63:0] hist_count;
`endif
  int checks = 0, errors = 0;
  lfsr_checker dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_bits(in_bits),
    .clear_stats(clear_stats),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .sample_count(sample_count),
`ifdef LFSR_CHECK_HIST_EN
    .hist_count(hist_count),
`endif
    .state_out(state_out)
  );
  always #5 clock = ~clock;
  typedef struct {logic v; logic [1:0] b; logic c; int st; int sc;} vec_t;
  vec_t tbl[8];
  int m_mode, m_run, m_err, m_samp, m_pulse;
  int m_hist[4];
  int win[$];
  logic [10:0] m_pred, gen;
  function automatic logic [10:0] adv(input logic [10:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[1] ^ s[3], s[0] ^ s[2], s[10:2]};
    return s;
  endfunction
  function automatic int sat(input int x);
    return x < 65535 ? x + 1 : x;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_mode = 0; m_run = 0; m_err = 0; m_samp = 0; m_pulse = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    win.delete();
  endtask
  task automatic m_step(input logic v, input logic [1:0] b, input logic c);
    logic [10:0] s;
    logic hit;
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        win.push_back(int'(b));
        if (win.size() == 6) begin
          s = '0;
          for (int j = 0; j < 6; j++) s = s | (11'(win[j]) << (2 * j));
          win.delete();
          if (s != 0) begin
            m_pred = adv(s, 6);
            m_mode = 1;
            m_run = 0;
          end
        end
      end else begin
        hit = b == m_pred[1:0];
        m_pred = adv(m_pred, 1);
        if (m_mode == 1) begin
          if (!hit) m_mode = 0;
          else begin
            m_run++;
            if (m_run == 8) begin m_mode = 2; m_run = 0; end
          end
        end else if (hit) m_run = 0;
        else begin
          m_pulse = 1;
          m_run++;
          if (m_run == 4) begin m_mode = 0; m_run = 0; end
        end
      end
    end
    if (c) begin
      m_err = 0; m_samp = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end else begin
      if (v) begin m_samp = sat(m_samp); m_hist[b] = sat(m_hist[b]); end
      if (m_pulse != 0) m_err = sat(m_err);
    end
  endtask
  task automatic cyc(input logic v, input logic [1:0] b, input logic c);
    in_valid = v; in_bits = b; clear_stats = c;
    @(posedge clock);
    #1;
    in_valid = 1'b0; clear_stats = 1'b0;
    m_step(v, b, c);
    chk("state_out", state_out, m_mode);
    chk("locked", locked, m_mode == 2);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_count", err_count, m_err);
    chk("sample_count", sample_count, m_samp);
`ifdef LFSR_CHECK_HIST_EN
    for (int i = 0; i < 4; i++) chk("hist_count", hist_count[i*16 +: 16], m_hist[i]);
`endif
  endtask
  task automatic send(input logic [1:0] flip);
    cyc(1'b1, gen[1:0] ^ flip, 1'b0);
    gen = adv(gen, 1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_reset();
    chk("rst_state", state_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_err", err_count, 0);
    chk("rst_samples", sample_count, 0);
    reset = 1'b0;
  endtask
  task automatic lock_run(input string tag);
    for (int i = 0; i < 14; i++) begin
      send(2'd0);
      chk(tag, locked, i == 13);
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 2'd0, 1'b0, 0, 1};
    tbl[1] = '{1'b0, 2'd3, 1'b0, 0, 1};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 0, 2};
    tbl[3] = '{1'b1, 2'd2, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 0, 1};
    tbl[5] = '{1'b0, 2'd0, 1'b1, 0, 0};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 0, 1};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 1, 2};
    m_reset();
    #12;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].c);
      chk("tbl_state", state_out, tbl[i].st);
      chk("tbl_samples", sample_count, tbl[i].sc);
    end
    do_reset();
    gen = 11'd101;
    lock_run("clean_lock");
    for (int i = 14; i < 2047; i++) send(2'd0);
    chk("clean_err", err_count, 0);
    chk("clean_samples", sample_count, 2047);
`ifdef LFSR_CHECK_HIST_EN
    chk("hist00", hist_count[15:0], 511);
    chk("hist01", hist_count[31:16], 512);
    chk("hist10", hist_count[47:32], 512);
    chk("hist11", hist_count[63:48], 512);
`endif
    send(2'd1);
    chk("single_pulse", err_pulse, 1);
    chk("single_err", err_count, 1);
    chk("single_locked", locked, 1);
    send(2'd0);
    chk("single_pulse_end", err_pulse, 0);
    chk("single_locked2", locked, 1);
    cyc(1'b0, 2'd0, 1'b1);
    chk("clear_idle", err_count, 0);
    for (int i = 0; i < 4; i++) send(2'd1);
    chk("loss_err", err_count, 4);
    chk("loss_locked", locked, 0);
    lock_run("relock");
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1'b1, 2'd0, 1'b0);
    chk("zero_state", state_out, 0);
    chk("zero_locked", locked, 0);
    chk("zero_err", err_count, 0);
    chk("zero_samples", sample_count, 100);
    do_reset();
    gen = 11'h5a3;
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 2'($urandom), 1'b0);
      chk("gap_hold", locked, i > 13);
      send(2'd0);
      chk("gap_lock", locked, i == 13);
    end
    cyc(1'b1, gen[1:0], 1'b1);
    gen = adv(gen, 1);
    chk("clear_samples", sample_count, 0);
    chk("clear_err", err_count, 0);
    chk("clear_locked", locked, 1);
    for (int i = 0; i < 5; i++) send(2'd0);
    do_reset();
    lock_run("rst_relock");
    for (int blk = 0; blk < 4; blk++)
      for (int i = 0; i < 800; i++) begin
        logic [1:0] f;
        f = ($urandom_range(0, (blk % 2 == 0) ? 39 : 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        if ($urandom_range(0, 3) != 0) begin
          cyc(1'b1, gen[1:0] ^ f, $urandom_range(0, 49) == 0);
          gen = adv(gen, 1);
        end else cyc(1'b0, 2'($urandom), $urandom_range(0, 49) == 0);
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
